// File: rtl/adder_sched_ctrl_pkg.sv
// Shared types and defaults for the time-shared slice adder scheduler.
// Holds FSM state encoding, requester IDs and round-robin pick helper.
package adder_sched_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic {
        REQ_ID0 = 1'b0,
        REQ_ID1 = 1'b1
    } req_id_t;

    // On a tie the requester not granted last wins; a single request always wins.
    function automatic req_id_t rr_pick(input logic req0, input logic req1, input req_id_t last_id);
        req_id_t pick;
        if (req0 && req1) begin
            pick = (last_id == REQ_ID0) ? REQ_ID1 : REQ_ID0;
        end else if (req1) begin
            pick = REQ_ID1;
        end else begin
            pick = REQ_ID0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/bit8adder.sv
// Plain 8-bit ripple adder slice with carry in/out.
module bit8adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] w_total;

    assign w_total = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign sum     = w_total[7:0];
    assign cout    = w_total[8];

endmodule

// File: rtl/adder_sched_ctrl.sv
// Two-requester round-robin scheduler sharing one 8-bit adder slice;
// a WIDTH-bit add runs over WIDTH/SLICE cycles, one slice per cycle.
module adder_sched_ctrl
    import adder_sched_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t           r_state;
    req_id_t          r_last_id;
    req_id_t          r_owner;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_gnt0, r_gnt1, r_busy, r_done, r_done_id, r_cout;
    logic [WIDTH-1:0] r_sum;

    req_id_t          w_pick;
    logic [SLICE-1:0] w_a_slice, w_b_slice, w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_result;

    // Arbitration pick and slice selection for the current cycle.
    always_comb begin
        w_pick    = rr_pick(req0, req1, r_last_id);
        w_a_slice = r_a[r_idx*SLICE +: SLICE];
        w_b_slice = r_b[r_idx*SLICE +: SLICE];
        w_result  = r_acc;
        w_result[r_idx*SLICE +: SLICE] = w_slice_sum;
    end

    bit8adder u_slice (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Scheduler FSM: grant and latch in IDLE, one slice per RUN cycle, pulse done after DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last_id <= REQ_ID1;
            r_owner   <= REQ_ID0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_cout    <= 1'b0;
            r_sum     <= '0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_owner   <= w_pick;
                        r_last_id <= w_pick;
                        r_gnt0    <= (w_pick == REQ_ID0);
                        r_gnt1    <= (w_pick == REQ_ID1);
                        r_a       <= (w_pick == REQ_ID1) ? a1 : a0;
                        r_b       <= (w_pick == REQ_ID1) ? b1 : b0;
                        r_carry   <= (w_pick == REQ_ID1) ? cin1 : cin0;
                        r_idx     <= '0;
                        r_acc     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end else begin
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_result;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_sum     <= w_result;
                        r_cout    <= w_slice_cout;
                        r_done_id <= r_owner;
                        r_state   <= ST_DONE;
                    end else begin
                        r_state   <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign sum     = r_sum;
    assign cout    = r_cout;

endmodule
